// File: rtl/rv_pkg.sv
// rv_pkg: shared types and helpers for the rv32 MEM stage load/store path.
//   mem_size_t   - access width (BYTE, HWORD, WORD)
//   lsu_state_t  - load/store unit sequencing states
//   lsu_fault_t  - fault code reported with every completed access
//   be_from_size, misaligned, replicate_wdata, load_extend - lane helpers
package rv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HWORD = 2'd1,
        MEM_WORD  = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        CH_WAIT = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_UNMAPPED = 2'd2,
        FLT_TIMEOUT  = 2'd3
    } lsu_fault_t;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_from_size(mem_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE:  return 4'b0001 << off;
            MEM_HWORD: return 4'b0011 << off;
            default:   return 4'b1111;
        endcase
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic misaligned(mem_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE:  return 1'b0;
            MEM_HWORD: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

    // Replicate the low byte/halfword across the word so every lane carries it;
    // the byte enables then pick the lane that is actually written.
    function automatic logic [31:0] replicate_wdata(mem_size_t size, logic [31:0] d);
        case (size)
            MEM_BYTE:  return {4{d[7:0]}};
            MEM_HWORD: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then zero- or sign-extend.
    function automatic logic [31:0] load_extend(logic [31:0] word, mem_size_t size,
                                                logic sext, logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            MEM_BYTE:  return {{24{sext & sh[7]}}, sh[7:0]};
            MEM_HWORD: return {{16{sext & sh[15]}}, sh[15:0]};
            default:   return sh;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem: local data RAM, DEPTH x 32-bit words, byte-enabled write and
// registered (synchronous) read. Contents are never reset.
//   i_clk    clock
//   i_we     write strobe, lanes selected by i_be
//   i_re     read strobe; o_rdata updates at the following edge
//   i_addr   word index
//   i_be     byte enables
//   i_wdata  write data (already lane-replicated)
//   o_rdata  registered read data
module lsu_dmem #(
    parameter int DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [3:0]               i_be,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_lsu_bus.sv
// mem_lsu_bus: MEM-stage load/store unit. Decodes each request to the local
// data RAM, one of N_CH MMIO channels (ready handshake, timeout) or unmapped,
// and reports misaligned/unmapped/timeout faults together with o_done.
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_req_valid, i_we, i_re          request from EX/MEM (store / load)
//   i_addr, i_wdata, i_size, i_sign_ext  address, store data, width, load sign
//   o_stall, o_done, o_rdata, o_fault    pipeline hold and completion result
//   o_ch_sel/we/addr/wdata/be        registered MMIO request strobes
//   i_ch_ready, i_ch_rdata           per-channel ready and read data
module mem_lsu_bus
    import rv_pkg::*;
#(
    parameter int          N_CH        = 2,
    parameter int          DMEM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h100,
    parameter logic [31:0] MMIO_STRIDE = 32'h100,
    parameter int          TIMEOUT     = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  mem_size_t          i_size,
    input  logic               i_sign_ext,
    output logic               o_stall,
    output logic               o_done,
    output logic [31:0]        o_rdata,
    output logic [1:0]         o_fault,
    output logic [N_CH-1:0]    o_ch_sel,
    output logic               o_ch_we,
    output logic [31:0]        o_ch_addr,
    output logic [31:0]        o_ch_wdata,
    output logic [3:0]         o_ch_be,
    input  logic [N_CH-1:0]    i_ch_ready,
    input  logic [N_CH*32-1:0] i_ch_rdata
);

    localparam int          DM_AW     = $clog2(DMEM_WORDS);
    localparam int          STRIDE_SH = $clog2(MMIO_STRIDE);
    localparam int          CH_IW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int          CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [32:0] RAM_LIMIT = 33'(DMEM_WORDS) << 2;
    localparam logic [32:0] CH_SPAN   = 33'(N_CH) * {1'b0, MMIO_STRIDE};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // ---------------- request decode ----------------
    logic             accept;
    logic [31:0]      ch_off;
    logic             ram_hit;
    logic             ch_hit;
    logic             mis;
    logic [CH_IW-1:0] ch_idx;
    logic [N_CH-1:0]  ch_onehot;
    logic [3:0]       be_in;
    logic [31:0]      wdata_in;

    // Requests are ignored while reset is held so no RAM write can land on
    // the reset edge and no result is reported during reset.
    assign accept    = i_req_valid & (i_we | i_re) & ~i_rst;
    // Addresses below MMIO_BASE wrap to large offsets and miss every window.
    assign ch_off    = i_addr - MMIO_BASE;
    assign ram_hit   = {1'b0, i_addr} < RAM_LIMIT;
    assign ch_hit    = {1'b0, ch_off} < CH_SPAN;
    assign mis       = misaligned(i_size, i_addr[1:0]);
    assign ch_idx    = CH_IW'(ch_off >> STRIDE_SH);
    assign ch_onehot = N_CH'(1) << ch_idx;
    assign be_in     = be_from_size(i_size, i_addr[1:0]);
    assign wdata_in  = replicate_wdata(i_size, i_wdata);

    // ---------------- state ----------------
    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  ch_sel_q, ch_sel_d;
    logic             ch_we_q, ch_we_d;
    logic [31:0]      ch_addr_q, ch_addr_d;
    logic [31:0]      ch_wdata_q, ch_wdata_d;
    logic [3:0]       ch_be_q, ch_be_d;
    logic [CH_IW-1:0] ch_idx_q, ch_idx_d;
    logic             st_q, st_d;
    mem_size_t        size_q, size_d;
    logic             sext_q, sext_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      cap_q, cap_d;
    lsu_fault_t       flt_q, flt_d;

    // ---------------- RAM ----------------
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    lsu_dmem #(
        .DEPTH (DMEM_WORDS)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_re    (ram_re),
        .i_addr  (i_addr[DM_AW+1:2]),
        .i_be    (be_in),
        .i_wdata (wdata_in),
        .o_rdata (ram_rdata)
    );

    // ---------------- channel return mux ----------------
    logic        ready_sel;
    logic [31:0] rdata_sel;

    assign ready_sel = i_ch_ready[ch_idx_q];
    assign rdata_sel = i_ch_rdata[32*ch_idx_q +: 32];

    // ---------------- next state / outputs ----------------
    logic        done;
    logic [31:0] rdata;
    lsu_fault_t  fault;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_sel_d   = ch_sel_q;
        ch_we_d    = ch_we_q;
        ch_addr_d  = ch_addr_q;
        ch_wdata_d = ch_wdata_q;
        ch_be_d    = ch_be_q;
        ch_idx_d   = ch_idx_q;
        st_d       = st_q;
        size_d     = size_q;
        sext_d     = sext_q;
        off_d      = off_q;
        cap_d      = cap_q;
        flt_d      = flt_q;
        done       = 1'b0;
        rdata      = '0;
        fault      = FLT_NONE;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Latched unconditionally; only multi-cycle paths use them.
                    ch_idx_d = ch_idx;
                    st_d     = i_we;
                    size_d   = i_size;
                    sext_d   = i_sign_ext;
                    off_d    = i_addr[1:0];
                    if (mis) begin
                        done  = 1'b1;
                        fault = FLT_MISALIGN;
                    end else if (ram_hit) begin
                        if (i_we) begin
                            ram_we = 1'b1;
                            done   = 1'b1;
                        end else begin
                            ram_re  = 1'b1;
                            state_d = RAM_RD;
                        end
                    end else if (ch_hit) begin
                        ch_sel_d   = ch_onehot;
                        ch_we_d    = i_we;
                        ch_addr_d  = ch_off & (MMIO_STRIDE - 32'd1);
                        ch_wdata_d = wdata_in;
                        ch_be_d    = be_in;
                        cnt_d      = '0;
                        state_d    = CH_WAIT;
                    end else begin
                        done  = 1'b1;
                        fault = FLT_UNMAPPED;
                    end
                end
            end
            RAM_RD: begin
                done    = 1'b1;
                rdata   = load_extend(ram_rdata, size_q, sext_q, off_q);
                state_d = IDLE;
            end
            CH_WAIT: begin
                // Ready is tested first so it wins over a coincident timeout.
                if (ready_sel || cnt_q == CNT_MAX) begin
                    cap_d      = ready_sel ? rdata_sel : 32'd0;
                    flt_d      = ready_sel ? FLT_NONE : FLT_TIMEOUT;
                    ch_sel_d   = '0;
                    ch_we_d    = 1'b0;
                    ch_addr_d  = '0;
                    ch_wdata_d = '0;
                    ch_be_d    = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                done    = 1'b1;
                fault   = flt_q;
                rdata   = st_q ? 32'd0 : load_extend(cap_q, size_q, sext_q, off_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_sel_q   <= '0;
            ch_we_q    <= 1'b0;
            ch_addr_q  <= '0;
            ch_wdata_q <= '0;
            ch_be_q    <= '0;
            ch_idx_q   <= '0;
            st_q       <= 1'b0;
            size_q     <= MEM_BYTE;
            sext_q     <= 1'b0;
            off_q      <= '0;
            cap_q      <= '0;
            flt_q      <= FLT_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_sel_q   <= ch_sel_d;
            ch_we_q    <= ch_we_d;
            ch_addr_q  <= ch_addr_d;
            ch_wdata_q <= ch_wdata_d;
            ch_be_q    <= ch_be_d;
            ch_idx_q   <= ch_idx_d;
            st_q       <= st_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            off_q      <= off_d;
            cap_q      <= cap_d;
            flt_q      <= flt_d;
        end
    end

    assign o_done     = done;
    assign o_rdata    = rdata;
    assign o_fault    = fault;
    assign o_stall    = i_req_valid & ~done & ~i_rst;
    assign o_ch_sel   = ch_sel_q;
    assign o_ch_we    = ch_we_q;
    assign o_ch_addr  = ch_addr_q;
    assign o_ch_wdata = ch_wdata_q;
    assign o_ch_be    = ch_be_q;

endmodule

// File: tb/tb_mem_lsu_bus.sv
// Testbench for mem_lsu_bus: table of access vectors driven one at a time,
// expected results queued at drive time and popped when o_done appears,
// plus hand-written reset-mid-access and flush sequences.
module tb_mem_lsu_bus;
    import rv_pkg::*;

    localparam int N_CH = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_req_valid;
    logic              i_we;
    logic              i_re;
    logic [31:0]       i_addr;
    logic [31:0]       i_wdata;
    mem_size_t         i_size;
    logic              i_sign_ext;
    logic              o_stall;
    logic              o_done;
    logic [31:0]       o_rdata;
    logic [1:0]        o_fault;
    logic [N_CH-1:0]   o_ch_sel;
    logic              o_ch_we;
    logic [31:0]       o_ch_addr;
    logic [31:0]       o_ch_wdata;
    logic [3:0]        o_ch_be;
    logic [N_CH-1:0]   i_ch_ready;
    logic [N_CH*32-1:0] i_ch_rdata;

    mem_lsu_bus #(
        .N_CH        (N_CH),
        .DMEM_WORDS  (64),
        .MMIO_BASE   (32'h100),
        .MMIO_STRIDE (32'h100),
        .TIMEOUT     (15)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_we        (i_we),
        .i_re        (i_re),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_size      (i_size),
        .i_sign_ext  (i_sign_ext),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_fault     (o_fault),
        .o_ch_sel    (o_ch_sel),
        .o_ch_we     (o_ch_we),
        .o_ch_addr   (o_ch_addr),
        .o_ch_wdata  (o_ch_wdata),
        .o_ch_be     (o_ch_be),
        .i_ch_ready  (i_ch_ready),
        .i_ch_rdata  (i_ch_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        mem_size_t   size;
        logic        sext;
        int          delay;      // CH_WAIT cycle index at which ready is given; -1 = never
        logic [31:0] chrd;       // data returned by the addressed channel
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
        int          exp_stall;
        logic [1:0]  exp_sel;
        logic [3:0]  exp_be;
        logic [31:0] exp_chwd;
        logic [31:0] exp_chaddr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, id, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata, input mem_size_t size, input logic sext,
                       input int delay, input logic [31:0] chrd,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_fault,
                       input int exp_stall, input logic [1:0] exp_sel,
                       input logic [3:0] exp_be, input logic [31:0] exp_chwd,
                       input logic [31:0] exp_chaddr);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.size = size;
        v.sext = sext; v.delay = delay; v.chrd = chrd; v.exp_rdata = exp_rdata;
        v.exp_fault = exp_fault; v.exp_stall = exp_stall; v.exp_sel = exp_sel;
        v.exp_be = exp_be; v.exp_chwd = exp_chwd; v.exp_chaddr = exp_chaddr;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge; returns just after a rising edge with
    // the request withdrawn.
    task automatic run_vec(input vec_t v, input int id);
        vec_t        e;
        int          stalls = 0;
        int          j = 0;
        bit          got = 0;
        logic [1:0]  sel_seen = '0;
        logic        we_seen = 1'b0;
        logic [3:0]  be_seen = '0;
        logic [31:0] wd_seen = '0;
        logic [31:0] ad_seen = '0;
        i_req_valid = 1'b1;
        i_we        = v.we;
        i_re        = v.re;
        i_addr      = v.addr;
        i_wdata     = v.wdata;
        i_size      = v.size;
        i_sign_ext  = v.sext;
        i_ch_ready  = '0;
        // Addressed channel returns chrd, the other returns its inverse.
        i_ch_rdata  = (v.exp_sel == 2'b10) ? {v.chrd, ~v.chrd} : {~v.chrd, v.chrd};
        exp_q.push_back(v);
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(negedge i_clk);
            if (o_ch_sel != '0) begin
                if (sel_seen == '0) begin
                    sel_seen = o_ch_sel; we_seen = o_ch_we; be_seen = o_ch_be;
                    wd_seen  = o_ch_wdata; ad_seen = o_ch_addr;
                end
                i_ch_ready = (j == v.delay) ? o_ch_sel : '0;
                j++;
            end else begin
                i_ch_ready = '0;
            end
            if (o_done) begin
                got = 1;
                e = exp_q.pop_front();
                chk("rdata", id, o_rdata, e.exp_rdata);
                chk("fault", id, 32'(o_fault), 32'(e.exp_fault));
                chk("stall_cycles", id, stalls, e.exp_stall);
                chk("ch_sel", id, 32'(sel_seen), 32'(e.exp_sel));
                if (e.exp_sel != '0) begin
                    chk("ch_we", id, 32'(we_seen), 32'(e.we));
                    chk("ch_be", id, 32'(be_seen), 32'(e.exp_be));
                    chk("ch_wdata", id, wd_seen, e.exp_chwd);
                    chk("ch_addr", id, ad_seen, e.exp_chaddr);
                end
                $display("[TB] vec%0d addr=0x%08h we=%0d rdata=0x%08h fault=%0d stalls=%0d",
                         id, v.addr, v.we, o_rdata, o_fault, stalls);
            end else if (o_stall) begin
                stalls++;
            end
        end
        if (!got) begin
            chk("done_timeout", id, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_ch_ready  = '0;
    endtask

    initial begin
        bit seen;
        int nv1;
        i_rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_re = 1'b0;
        i_addr = '0; i_wdata = '0; i_size = MEM_WORD; i_sign_ext = 1'b0;
        i_ch_ready = '0; i_ch_rdata = '0;

        //   we re addr        wdata         size      sx dly chrd          rdata         flt stl sel    be       chwd          chaddr
        add(1, 0, 32'h010, 32'hDEADBEEF, MEM_WORD,  0, -1, 32'h0,       32'h0,        0, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h013, 32'h0,        MEM_BYTE,  1, -1, 32'h0,       32'hFFFFFFDE, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h010, 32'h0,        MEM_HWORD, 0, -1, 32'h0,       32'h0000BEEF, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h011, 32'h0,        MEM_BYTE,  0, -1, 32'h0,       32'h000000BE, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h012, 32'h0,        MEM_HWORD, 1, -1, 32'h0,       32'hFFFFDEAD, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h201, 32'h1234565A, MEM_BYTE,  0,  3, 32'h0,       32'h0,        0, 5,  2'b10, 4'b0010, 32'h5A5A5A5A, 32'h1);
        add(0, 1, 32'h104, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h0,        3, 17, 2'b01, 4'hF,    32'h0,        32'h4);
        add(0, 1, 32'h012, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h0,        1, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h012, 32'h11111111, MEM_WORD,  0, -1, 32'h0,       32'h0,        1, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h011, 32'h00002222, MEM_HWORD, 0, -1, 32'h0,       32'h0,        1, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h010, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'hDEADBEEF, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h900, 32'h55555555, MEM_WORD,  0, -1, 32'h0,       32'h0,        2, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h300, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h0,        2, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h204, 32'h0,        MEM_WORD,  0, 15, 32'hCAFEF00D, 32'hCAFEF00D, 0, 17, 2'b10, 4'hF,    32'h0,        32'h4);
        add(0, 1, 32'h106, 32'h0,        MEM_HWORD, 1,  0, 32'h80011234, 32'hFFFF8001, 0, 2,  2'b01, 4'b1100, 32'h0,        32'h6);
        add(0, 1, 32'h2FF, 32'h0,        MEM_BYTE,  0,  1, 32'hA5000000, 32'h000000A5, 0, 3,  2'b10, 4'b1000, 32'h0,        32'hFF);
        add(1, 0, 32'h0FC, 32'h11223344, MEM_WORD,  0, -1, 32'h0,       32'h0,        0, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h0FC, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h11223344, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h012, 32'hABCD7777, MEM_HWORD, 0, -1, 32'h0,       32'h0,        0, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h010, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h7777BEEF, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(1, 0, 32'h102, 32'h00009876, MEM_HWORD, 0,  2, 32'h0,       32'h0,        0, 4,  2'b01, 4'b1100, 32'h98769876, 32'h2);
        add(1, 0, 32'h0FF, 32'h000000C3, MEM_BYTE,  0, -1, 32'h0,       32'h0,        0, 0,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h0FC, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'hC3223344, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        nv1 = vecs.size();
        // Run after the reset-mid-access sequence.
        add(0, 1, 32'h010, 32'h0,        MEM_WORD,  0, -1, 32'h0,       32'h7777BEEF, 0, 1,  2'b00, 4'h0,    32'h0,        32'h0);
        add(0, 1, 32'h100, 32'h0,        MEM_WORD,  0,  2, 32'h13572468, 32'h13572468, 0, 4,  2'b01, 4'hF,    32'h0,        32'h0);

        // Reset state.
        repeat (2) @(negedge i_clk);
        chk("rst_ch_sel", 0, 32'(o_ch_sel), 32'h0);
        chk("rst_ch_we", 0, 32'(o_ch_we), 32'h0);
        chk("rst_ch_addr", 0, o_ch_addr, 32'h0);
        chk("rst_ch_wdata", 0, o_ch_wdata, 32'h0);
        chk("rst_ch_be", 0, 32'(o_ch_be), 32'h0);
        chk("rst_rdata", 0, o_rdata, 32'h0);
        chk("rst_fault", 0, 32'(o_fault), 32'h0);
        chk("rst_done", 0, 32'(o_done), 32'h0);
        chk("rst_stall", 0, 32'(o_stall), 32'h0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        for (int k = 0; k < nv1; k++) begin
            run_vec(vecs[k], k);
        end

        // Reset while a channel load is waiting for a ready that never comes.
        i_req_valid = 1'b1; i_we = 1'b0; i_re = 1'b1; i_addr = 32'h104;
        i_size = MEM_WORD; i_sign_ext = 1'b0; i_wdata = '0; i_ch_ready = '0;
        repeat (3) @(negedge i_clk);
        chk("pre_rst_sel", 100, 32'(o_ch_sel), 32'h1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_sel", 100, 32'(o_ch_sel), 32'h0);
        chk("midrst_be", 100, 32'(o_ch_be), 32'h0);
        chk("midrst_stall", 100, 32'(o_stall), 32'h0);
        chk("midrst_done", 100, 32'(o_done), 32'h0);
        // A store presented across the reset edge must not reach the RAM.
        i_re = 1'b0; i_we = 1'b1; i_addr = 32'h010; i_wdata = 32'h0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_req_valid = 1'b0;
        $display("[TB] reset during CH_WAIT applied");
        for (int k = nv1; k < vecs.size(); k++) begin
            run_vec(vecs[k], k);
        end

        // Flush: request withdrawn in CH_WAIT, access still completes.
        i_req_valid = 1'b1; i_we = 1'b0; i_re = 1'b1; i_addr = 32'h204;
        i_size = MEM_WORD; i_sign_ext = 1'b0; i_wdata = '0;
        i_ch_rdata = {32'h0BADF00D, 32'hF4520FF2};
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge i_clk);
            if (o_ch_sel != '0) seen = 1;
        end
        chk("flush_sel_seen", 200, 32'(seen), 32'h1);
        chk("flush_sel", 200, 32'(o_ch_sel), 32'h2);
        i_req_valid = 1'b0;
        i_ch_ready  = 2'b10;
        @(negedge i_clk);
        i_ch_ready = '0;
        chk("flush_done", 200, 32'(o_done), 32'h1);
        chk("flush_rdata", 200, o_rdata, 32'h0BADF00D);
        chk("flush_stall", 200, 32'(o_stall), 32'h0);
        @(negedge i_clk);
        chk("flush_idle_done", 200, 32'(o_done), 32'h0);
        chk("flush_idle_sel", 200, 32'(o_ch_sel), 32'h0);
        $display("[TB] flush sequence rdata=0x%08h", o_rdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
